// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// No ports; provides slot layout, pointer/counter width helpers and the
// NOP encoding used when no instruction is presented.
package ifu_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int INST_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  // RV NOP (addi x0, x0, 0), shared with the pipeline-flush logic.
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic                  filled;
  } slot_t;

  // Pointer width indexes DEPTH slots; counters need one more bit to hold DEPTH.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
  localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);

endpackage

// File: rtl/ifu_prefetch_if.sv
// Fetch-unit bus bundle: memory request/response, redirect, and IF/ID output.
// master : the prefetch unit (drives req_*, out_*, err)
// slave  : the environment (memory, branch resolution, IF/ID stage)
interface ifu_prefetch_if #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              resp_valid;
  logic [INST_W-1:0] resp_inst;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              err;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_inst, err,
    input  req_ready, resp_valid, resp_inst, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_inst, err,
    output req_ready, resp_valid, resp_inst, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifu_slot_queue.sv
// Circular slot buffer for the prefetch unit.
// reserve/reserve_pc : claim tail slot for an issued fetch (unfilled)
// fill/fill_inst     : write the oldest unfilled slot with returned data
// pop                : retire the head slot
// flush              : drop every slot and equalise pointers
// head_*             : contents of the head slot
// live_cnt           : reserved slots (filled or not)
// unfilled_cnt       : reserved slots still waiting for their response
module ifu_slot_queue
  import ifu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              reserve,
  input  logic [XLEN-1:0]   reserve_pc,
  input  logic              fill,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop,
  output logic              head_filled,
  output logic [XLEN-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic [CNT_W-1:0]  live_cnt,
  output logic [CNT_W-1:0]  unfilled_cnt
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  filled;
  logic [PTR_W-1:0]  head_ptr;
  logic [PTR_W-1:0]  fill_ptr;
  logic [PTR_W-1:0]  tail_ptr;

  // Control state: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      filled       <= '0;
      head_ptr     <= '0;
      fill_ptr     <= '0;
      tail_ptr     <= '0;
      live_cnt     <= '0;
      unfilled_cnt <= '0;
    end else begin
      if (pop) begin
        filled[head_ptr] <= 1'b0;
        head_ptr         <= head_ptr + PTR_W'(1);
      end
      if (fill) begin
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + PTR_W'(1);
      end
      if (reserve) begin
        filled[tail_ptr] <= 1'b0;
        tail_ptr         <= tail_ptr + PTR_W'(1);
      end
      live_cnt     <= live_cnt + CNT_W'(reserve) - CNT_W'(pop);
      unfilled_cnt <= unfilled_cnt + CNT_W'(reserve) - CNT_W'(fill);
    end
  end

  // Slot payload carries no reset; the filled bits qualify it.
  always_ff @(posedge clk) begin
    if (reserve && !flush) pc_mem[tail_ptr]   <= reserve_pc;
    if (fill && !flush)    inst_mem[fill_ptr] <= fill_inst;
  end

  assign head_filled = filled[head_ptr];
  assign head_pc     = pc_mem[head_ptr];
  assign head_inst   = inst_mem[head_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit with an in-order prefetch queue.
// clk, rst : single clock, synchronous active-high reset
// bus      : ifu_prefetch_if.master -- memory request/response, redirect
//            from branch resolution, valid/ready output to IF/ID, sticky err
// Holds the fetch PC, the count of stale in-flight responses to discard,
// the error flag, and issue/redirect control around ifu_slot_queue.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic          clk,
  input  logic          rst,
  ifu_prefetch_if.master bus
);

  localparam int              CNT_W   = cnt_w(DEPTH);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  live_cnt;
  logic [CNT_W-1:0]  unfilled_cnt;
  logic              err_q;
  logic              head_filled;
  logic [XLEN-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;
  logic [CNT_W:0]    occupancy;
  logic              req_fire;
  logic              resp_owed;
  logic              resp_drop;
  logic              resp_fill;
  logic              resp_stray;
  logic              pop;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // Slots reserved plus stale responses still owed bound the requests in flight.
  assign occupancy  = {1'b0, live_cnt} + {1'b0, drop_cnt};
  assign bus.req_valid = !bus.redirect_valid && (occupancy < DEPTH_C);
  assign bus.req_addr  = fetch_pc;
  assign req_fire   = bus.req_valid && bus.req_ready;

  // Responses arrive in order: stale ones first, then those for live slots.
  // A response during a redirect belongs to a slot being flushed.
  assign resp_owed  = (drop_cnt != '0) || (unfilled_cnt != '0);
  assign resp_drop  = bus.resp_valid && (drop_cnt != '0);
  assign resp_fill  = bus.resp_valid && (drop_cnt == '0) && (unfilled_cnt != '0)
                      && !bus.redirect_valid;
  assign resp_stray = bus.resp_valid && !resp_owed;

  assign bus.out_valid = head_filled && !bus.redirect_valid;
  assign bus.out_pc    = head_pc;
  assign bus.out_inst  = bus.out_valid ? head_inst : INST_W'(NOP);
  assign bus.err       = err_q;
  assign pop           = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        // Every unfilled slot becomes a stale response, less one retired now.
        drop_cnt <= drop_cnt + unfilled_cnt - CNT_W'(bus.resp_valid && resp_owed);
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
      end
      if (resp_stray) err_q <= 1'b1;
    end
  end

  ifu_slot_queue #(
    .XLEN   (XLEN),
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush        (bus.redirect_valid),
    .reserve      (req_fire),
    .reserve_pc   (fetch_pc),
    .fill         (resp_fill),
    .fill_inst    (bus.resp_inst),
    .pop          (pop),
    .head_filled  (head_filled),
    .head_pc      (head_pc),
    .head_inst    (head_inst),
    .live_cnt     (live_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: a latency-programmable in-order memory and a
// queue-based reference of the fetch stream, checked every cycle.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int          XLEN     = 64;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_prefetch_if #(.XLEN(XLEN), .INST_W(INST_W)) bus ();

  ifu_prefetch #(
    .XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
    bit          stale;
  } mem_t;

  mem_t        mem_q[$];   // accepted requests not yet answered
  logic [63:0] m_buf[$];   // answered PCs waiting to be presented
  logic [63:0] m_next;
  bit          m_err;
  int          cyc_n, last_due;
  int          lat_min, lat_max, rr_pct, or_pct;
  int          vectors, miscompares;

  logic [162:0] obs, exp_s;
  logic         o_rv, o_ov, o_err, o_rr, fired, popped;
  logic [63:0]  o_addr, o_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_reset();
    mem_q.delete();
    m_buf.delete();
    m_next   = RESET_PC;
    m_err    = 1'b0;
    cyc_n    = 0;
    last_due = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst                = 1'b1;
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b0;
    @(posedge clk);
    model_reset();
  endtask

  // One clock: drive inputs, capture observed and reference outputs, advance model.
  task automatic cyc(input bit redir, input logic [63:0] rpc, input bit stray);
    bit   resp_now, exp_rv, exp_ov;
    int   d;
    mem_t e;
    logic [63:0] head;
    @(negedge clk);
    rst      = 1'b0;
    resp_now = (mem_q.size() > 0) && (mem_q[0].due <= cyc_n);
    bus.resp_valid     = resp_now || stray;
    bus.resp_inst      = resp_now ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    bus.req_ready      = ($urandom_range(99) < rr_pct);
    bus.out_ready      = ($urandom_range(99) < or_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    exp_rv = !redir && (mem_q.size() + m_buf.size() < DEPTH);
    exp_ov = !redir && (m_buf.size() > 0);
    head   = 64'h0;
    if (exp_ov) head = m_buf[0];
    exp_s = {exp_rv, m_next, exp_ov, head, exp_ov ? mem_word(head) : 32'h0, m_err};
    obs   = {bus.req_valid, bus.req_addr, bus.out_valid,
             exp_ov ? bus.out_pc : 64'h0, exp_ov ? bus.out_inst : 32'h0, bus.err};
    o_rv = bus.req_valid; o_addr = bus.req_addr; o_ov = bus.out_valid;
    o_pc = bus.out_pc;    o_err  = bus.err;      o_rr = bus.req_ready;
    fired  = exp_rv && bus.req_ready;
    popped = exp_ov && bus.out_ready;
    if (popped) void'(m_buf.pop_front());
    if (resp_now) begin
      e = mem_q.pop_front();
      if (!e.stale && !redir) m_buf.push_back(e.addr);
    end else if (stray && mem_q.size() == 0) begin
      m_err = 1'b1;
    end
    if (redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      m_buf.delete();
      m_next = {rpc[63:2], 2'b00};
    end
    if (fired) begin
      d = cyc_n + $urandom_range(lat_max, lat_min);
      if (d < last_due) d = last_due;
      last_due = d;
      mem_q.push_back('{m_next, d, 1'b0});
      m_next = m_next + 64'd4;
    end
    @(posedge clk);
    cyc_n++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({bus.req_valid, bus.out_valid, bus.err} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags got rv/ov/err=%b want 100", {bus.req_valid, bus.out_valid, bus.err});
    end
    vectors++;
    if (bus.req_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL reset_addr got %h want %h", bus.req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int first_out = -1, ov_cnt = 0;
    logic [63:0] first_pc = '0;
    do_reset();
    lat_min = 1; lat_max = 1; rr_pct = 100; or_pct = 100;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 64'h0, 1'b0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL stream cyc %0d got %h want %h", i, obs, exp_s);
      end
      if (i < 3) begin
        vectors++;
        if (o_addr !== RESET_PC + 64'(4 * i)) begin
          miscompares++;
          $display("FAIL stream_addr%0d got %h want %h", i, o_addr, RESET_PC + 64'(4 * i));
        end
      end
      if (o_ov && first_out < 0) begin first_out = i; first_pc = o_pc; end
      if (o_ov && i >= 2) ov_cnt++;
    end
    vectors++;
    if (first_out != 2 || first_pc !== RESET_PC) begin
      miscompares++;
      $display("FAIL stream_first got cyc %0d pc %h want cyc 2 pc %h", first_out, first_pc, RESET_PC);
    end
    vectors++;
    if (ov_cnt != 28) begin
      miscompares++;
      $display("FAIL stream_rate got %0d want 28", ov_cnt);
    end
  endtask

  task automatic test_backpressure();
    int fires = 0, pops = 0;
    logic [63:0] resume_addr = '0;
    bit resumed = 1'b0;
    do_reset();
    lat_min = 1; lat_max = 1; rr_pct = 100; or_pct = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 64'h0, 1'b0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL hold cyc %0d got %h want %h", i, obs, exp_s);
      end
      if (o_rv && o_rr) fires++;
    end
    vectors++;
    if (fires != 4 || o_rv !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_issue got %0d reqs rv=%b want 4 rv=0", fires, o_rv);
    end
    or_pct = 100;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 64'h0, 1'b0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL release cyc %0d got %h want %h", i, obs, exp_s);
      end
      if (o_ov && pops < 4) begin
        vectors++;
        if (o_pc !== RESET_PC + 64'(4 * pops)) begin
          miscompares++;
          $display("FAIL release_order got %h want %h", o_pc, RESET_PC + 64'(4 * pops));
        end
        pops++;
      end
      if (o_rv && o_rr && !resumed) begin resumed = 1'b1; resume_addr = o_addr; end
    end
    vectors++;
    if (resume_addr !== RESET_PC + 64'h10) begin
      miscompares++;
      $display("FAIL resume_addr got %h want %h", resume_addr, RESET_PC + 64'h10);
    end
  endtask

  task automatic test_redirect_inflight();
    logic [63:0] target = 64'h8000_0100, first_pc = '0;
    bit got = 1'b0;
    int bad = 0;
    do_reset();
    lat_min = 4; lat_max = 4; rr_pct = 100; or_pct = 100;
    for (int i = 0; i < 24; i++) begin
      cyc(i == 3, 64'h8000_0102, 1'b0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL redir cyc %0d got %h want %h", i, obs, exp_s);
      end
      if (i > 3 && o_ov) begin
        if (!got) begin got = 1'b1; first_pc = o_pc; end
        if (o_pc < target) bad++;
      end
    end
    vectors++;
    if (!got || first_pc !== target || bad != 0) begin
      miscompares++;
      $display("FAIL redir_first got %h (%0d flushed) want %h (0)", first_pc, bad, target);
    end
  endtask

  task automatic test_redirect_collide();
    logic [63:0] target = 64'h9000_0000, first_pc = '0;
    bit got = 1'b0;
    int bad = 0;
    do_reset();
    lat_min = 2; lat_max = 2; rr_pct = 100; or_pct = 100;
    for (int i = 0; i < 20; i++) begin
      cyc(i == 3, target, 1'b0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL collide cyc %0d got %h want %h", i, obs, exp_s);
      end
      if (i == 3) begin
        vectors++;
        if (o_ov !== 1'b0) begin
          miscompares++;
          $display("FAIL collide_ov got %b want 0", o_ov);
        end
      end
      if (i > 3 && o_ov) begin
        if (!got) begin got = 1'b1; first_pc = o_pc; end
        if (o_pc < target) bad++;
      end
    end
    vectors++;
    if (!got || first_pc !== target || bad != 0) begin
      miscompares++;
      $display("FAIL collide_first got %h (%0d stale) want %h (0)", first_pc, bad, target);
    end
  endtask

  task automatic test_err();
    do_reset();
    lat_min = 1; lat_max = 1; rr_pct = 0; or_pct = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 64'h0, i == 0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL err cyc %0d got %h want %h", i, obs, exp_s);
      end
    end
    vectors++;
    if ({o_err, o_ov, o_rv} !== 3'b101 || o_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL err_sticky got err/ov/rv=%b addr %h want 101 addr %h",
               {o_err, o_ov, o_rv}, o_addr, RESET_PC);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat_min = 2; lat_max = 2; rr_pct = 100; or_pct = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 64'h0, 1'b0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL midrst cyc %0d got %h want %h", i, obs, exp_s);
      end
    end
    do_reset();
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.req_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL midrst_after got ov=%b addr %h want ov=0 addr %h",
               bus.out_valid, bus.req_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    bit redir;
    do_reset();
    lat_min = 1; lat_max = 4; rr_pct = 70; or_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      r     = $urandom;
      redir = ($urandom_range(29) == 0);
      cyc(redir, {32'h0, 1'b1, r[30:0]}, 1'b0);
      vectors++;
      if (obs !== exp_s) begin
        miscompares++;
        $display("FAIL random cyc %0d got %h want %h", i, obs, exp_s);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_inst = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    lat_min = 1; lat_max = 1; rr_pct = 100; or_pct = 100;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
